// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 data cache controller.
// Ports: clock/reset, cpu_* load/store side, mem_* block memory side.
module dcache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int MEM_SIZE   = 32,
  parameter int NUM_LINES  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cpu_ren,
  input  logic                            cpu_wen,
  input  logic [ADDR_WIDTH-1:0]           cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_din,
  output logic [WORD_SIZE-1:0]            cpu_dout,
  output logic                            cpu_stall,
  output logic                            mem_ren,
  output logic                            mem_wen,
  output logic [$clog2(MEM_SIZE)-1:0]     mem_block_address,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_din,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_dout,
  input  logic                            mem_ready,
  input  logic                            mem_done
);

  localparam int BO_W  = $clog2(WORD_SIZE / 8);
  localparam int WO_W  = $clog2(BLOCK_SIZE);
  localparam int IX_W  = $clog2(NUM_LINES);
  localparam int BA_W  = $clog2(MEM_SIZE);
  localparam int TG_W  = BA_W - IX_W;
  localparam int BLK_W = WORD_SIZE * BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    GAP,
    ALLOCATE
  } state_t;

  state_t state;

  logic [BLK_W-1:0]     data_q [NUM_LINES];
  logic [TG_W-1:0]      tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  logic [IX_W-1:0] miss_idx;
  logic [TG_W-1:0] miss_tag;

  logic [WO_W-1:0] a_word;
  logic [IX_W-1:0] a_idx;
  logic [TG_W-1:0] a_tag;
  logic            req;
  logic            hit;
  logic [WORD_SIZE-1:0] rd_word;

  // Byte offset and bits above the block field never take part.
  logic unused_addr;
  assign unused_addr = ^cpu_addr;

  assign a_word = cpu_addr[BO_W +: WO_W];
  assign a_idx  = cpu_addr[BO_W+WO_W +: IX_W];
  assign a_tag  = cpu_addr[BO_W+WO_W+IX_W +: TG_W];

  // Both enables together is treated as no access at all.
  assign req = cpu_ren ^ cpu_wen;
  assign hit = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  assign rd_word = data_q[a_idx][a_word*WORD_SIZE +: WORD_SIZE];

  assign cpu_stall = req && ((state != IDLE) || !hit);
  assign cpu_dout  = (state == IDLE && cpu_ren && !cpu_wen && hit)
                   ? rd_word : '0;

  assign mem_ren = (state == ALLOCATE);
  assign mem_wen = (state == WRITEBACK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      valid_q           <= '0;
      dirty_q           <= '0;
      miss_idx          <= '0;
      miss_tag          <= '0;
      mem_block_address <= '0;
      mem_din           <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (req && hit) begin
            if (cpu_wen) begin
              data_q[a_idx][a_word*WORD_SIZE +: WORD_SIZE] <= cpu_din;
              dirty_q[a_idx] <= 1'b1;
            end
          end else if (req) begin
            miss_idx <= a_idx;
            miss_tag <= a_tag;
            if (valid_q[a_idx] && dirty_q[a_idx]) begin
              state             <= WRITEBACK;
              mem_block_address <= {tag_q[a_idx], a_idx};
              mem_din           <= data_q[a_idx];
            end else begin
              state             <= ALLOCATE;
              mem_block_address <= {a_tag, a_idx};
            end
          end
        end
        WRITEBACK: begin
          if (mem_done) begin
            state <= GAP;
          end
        end
        // Dead cycle lets the memory restart its latency count.
        GAP: begin
          state             <= ALLOCATE;
          mem_block_address <= {miss_tag, miss_idx};
        end
        ALLOCATE: begin
          if (mem_ready) begin
            data_q[miss_idx]  <= mem_dout;
            tag_q[miss_idx]   <= miss_tag;
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            state             <= IDLE;
          end
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && cpu_ren && cpu_wen) begin
      $display("dcache_ctrl: error: cpu_ren and cpu_wen both high, ignored");
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a behavioural block memory.
// Reference model tracks backing memory and line residency as arrays.
module tb_dcache_ctrl;

  localparam int NL = 4;
  localparam int MS = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_ren;
  logic         cpu_wen;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_din;
  logic [31:0]  cpu_dout;
  logic         cpu_stall;
  logic         mem_ren;
  logic         mem_wen;
  logic [4:0]   mem_block_address;
  logic [255:0] mem_din;
  logic [255:0] mem_dout;
  logic         mem_ready;
  logic         mem_done;

  dcache_ctrl dut (
    .clock(clock), .reset(reset),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_block_address(mem_block_address),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ready(mem_ready), .mem_done(mem_done)
  );

  always #5 clock = ~clock;

  // Block memory: ready/done after a programmable number of held cycles.
  logic [255:0] bmem [MS];
  int rcnt = 0;
  int wcnt = 0;
  int lat_rd = 1;
  int lat_wr = 1;

  assign mem_ready = mem_ren && (rcnt >= lat_rd - 1);
  assign mem_done  = mem_wen && (wcnt >= lat_wr - 1);
  assign mem_dout  = bmem[mem_block_address];

  always @(posedge clock) begin
    rcnt <= mem_ren ? rcnt + 1 : 0;
    wcnt <= mem_wen ? wcnt + 1 : 0;
    if (mem_wen && mem_done) bmem[mem_block_address] <= mem_din;
  end

  // Reference model.
  logic [31:0] ref_bmem [MS][8];
  logic [31:0] rcdata [NL][8];
  bit          rvalid [NL];
  bit          rdirty [NL];
  int          rblk   [NL];

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cycles;
    int          wb;
    int          rf;
  } exp_t;

  exp_t sbq [$];

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  bit abort = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, want);
    end
  endtask

  // Monitor: measures each access and pops its expectation on completion.
  int m_cyc = 0;
  int m_wb = 0;
  int m_rf = 0;
  bit m_ovl = 0;
  bit p_ren = 0;
  bit p_wen = 0;

  always @(negedge clock) begin
    exp_t e;
    if (reset || !(cpu_ren ^ cpu_wen)) begin
      m_cyc = 0; m_wb = 0; m_rf = 0; m_ovl = 0;
    end else begin
      m_cyc++;
      if (mem_wen && !p_wen) m_wb++;
      if (mem_ren && !p_ren) m_rf++;
      if (mem_ren && mem_wen) m_ovl = 1;
      if (!cpu_stall) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_completion: addr %h", cpu_addr);
        end else begin
          e = sbq.pop_front();
          chk("latency", 64'(m_cyc), 64'(e.cycles));
          chk("writebacks", 64'(m_wb), 64'(e.wb));
          chk("refills", 64'(m_rf), 64'(e.rf));
          chk("req_overlap", 64'(m_ovl), 64'd0);
          if (e.rd) chk("load_data", 64'(cpu_dout), 64'(e.data));
          else      chk("store_dout", 64'(cpu_dout), 64'd0);
        end
        m_cyc = 0; m_wb = 0; m_rf = 0; m_ovl = 0;
        n_done++;
      end
    end
    p_ren = mem_ren;
    p_wen = mem_wen;
  end

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic do_op(input bit wr, input logic [31:0] addr,
                       input logic [31:0] din);
    exp_t e;
    int blk, w, ln, prev, g;
    if (abort) return;
    blk = int'(addr[9:5]);
    w   = int'(addr[4:2]);
    ln  = blk % NL;
    e.rd = !wr; e.data = '0; e.cycles = 1; e.wb = 0; e.rf = 0;
    if (!(rvalid[ln] && rblk[ln] == blk)) begin
      if (rvalid[ln] && rdirty[ln]) begin
        e.wb = 1;
        e.cycles += lat_wr + 1;
        for (int k = 0; k < 8; k++) ref_bmem[rblk[ln]][k] = rcdata[ln][k];
      end
      e.rf = 1;
      e.cycles += lat_rd + 1;
      for (int k = 0; k < 8; k++) rcdata[ln][k] = ref_bmem[blk][k];
      rvalid[ln] = 1; rdirty[ln] = 0; rblk[ln] = blk;
    end
    if (wr) begin
      rcdata[ln][w] = din;
      rdirty[ln] = 1;
    end else begin
      e.data = rcdata[ln][w];
    end
    sbq.push_back(e);
    cpu_addr = addr; cpu_din = din; cpu_ren = !wr; cpu_wen = wr;
    prev = n_done; g = 0;
    while (n_done == prev && g < 200) begin
      @(posedge clock);
      g++;
    end
    if (n_done == prev) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: addr %h waited %0d cycles, required completion",
               addr, g);
      abort = 1;
    end
    #1;
    cpu_ren = 0; cpu_wen = 0;
  endtask

  task automatic reset_in_allocate();
    int ln, blk, g;
    if (abort) return;
    ln  = 0;
    blk = rvalid[ln] ? (rblk[ln] + NL) % MS : 0;
    if (rvalid[ln] && rdirty[ln])
      for (int k = 0; k < 8; k++) ref_bmem[rblk[ln]][k] = rcdata[ln][k];
    lat_rd = 2; lat_wr = 2;
    cpu_addr = {22'd0, 5'(blk), 3'd0, 2'd0};
    cpu_ren = 1; cpu_wen = 0;
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!mem_ren && g < 50);
    chk("reach_allocate", 64'(mem_ren), 64'd1);
    @(posedge clock); #1;
    reset = 1; cpu_ren = 0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_alloc_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_alloc_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_alloc_stall", 64'(cpu_stall), 64'd0);
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < NL; i++) begin
      rvalid[i] = 0; rdirty[i] = 0;
    end
  endtask

  task automatic random_ops(input int n);
    logic [31:0] r, a;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      a = {r[31:10], 5'($urandom_range(MS - 1)), 3'($urandom_range(7)),
           r[1:0]};
      lat_rd = $urandom_range(1, 4);
      lat_wr = $urandom_range(1, 4);
      do_op(1'($urandom_range(1)), a, $urandom());
      repeat ($urandom_range(2)) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int b = 0; b < MS; b++)
      for (int w = 0; w < 8; w++) begin
        v = $urandom();
        bmem[b][w*32 +: 32] = v;
        ref_bmem[b][w] = v;
      end
    bmem[0][31:0] = 32'h1111_1111;
    ref_bmem[0][0] = 32'h1111_1111;
    for (int i = 0; i < NL; i++) begin
      rvalid[i] = 0; rdirty[i] = 0; rblk[i] = 0;
    end

    reset = 1; cpu_ren = 0; cpu_wen = 0; cpu_addr = '0; cpu_din = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_dout", 64'(cpu_dout), 64'd0);
    chk("rst_addr", 64'(mem_block_address), 64'd0);
    chk("rst_din_lo", mem_din[63:0], 64'd0);
    @(posedge clock); #1;
    reset = 0;

    lat_rd = 3; lat_wr = 2;
    do_op(0, 32'h000, '0);
    do_op(0, 32'h004, '0);
    do_op(1, 32'h008, 32'hDEAD_BEEF);
    do_op(0, 32'h008, '0);
    chk("block0_untouched", 64'(bmem[0][95:64]), 64'(ref_bmem[0][2]));
    do_op(0, 32'h080, '0);
    chk("wb_word2", 64'(bmem[0][95:64]), 64'h0000_0000_DEAD_BEEF);
    do_op(0, 32'h008, '0);
    do_op(1, 32'h024, 32'hCAFE_F00D);
    do_op(0, 32'h024, '0);

    random_ops(150);

    reset_in_allocate();
    do_op(0, 32'h004, '0);
    do_op(0, 32'h000, '0);

    random_ops(60);

    repeat (3) @(posedge clock);
    if (sbq.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL pending: %0d expectations left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
